// File: rtl/pll_ce_gen.sv
// Clock-enable generator behind the system PLL: waits for a synchronised lock and a
// settling interval, then releases reset and emits NCH fractional-rate enable strobes.
module pll_ce_gen #(
    parameter int NCH           = 4,
    parameter int ACC_W         = 16,
    parameter int SETTLE_CYCLES = 1024
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 pll_lock,
    input  logic [NCH*ACC_W-1:0] step,
    input  logic [NCH*ACC_W-1:0] phase,
    input  logic                 phase_load,
    input  logic [NCH-1:0]       ch_en,
    output logic [NCH-1:0]       ce,
    output logic                 ready,
    output logic                 rst_out_n
);

    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        SETTLE    = 2'd1,
        RUN       = 2'd2
    } state_t;

    logic               r_sync1;
    logic               r_sync2;
    state_t             r_state;
    state_t             w_next;
    logic [CNT_W-1:0]   r_cnt;
    logic [ACC_W-1:0]   r_acc [NCH];
    logic [ACC_W:0]     w_sum [NCH];
    logic [NCH-1:0]     r_ce;
    logic               r_ready;
    logic               r_rst_out_n;
    logic               w_stay_run;
    logic               w_stay_settle;
    logic               w_run_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= pll_lock;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= WAIT_LOCK;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            WAIT_LOCK: if (r_sync2) w_next = SETTLE;
            SETTLE: begin
                if (!r_sync2) begin
                    w_next = WAIT_LOCK;
                end else if (r_cnt == CNT_W'(SETTLE_CYCLES - 1)) begin
                    w_next = RUN;
                end
            end
            RUN:     if (!r_sync2) w_next = WAIT_LOCK;
            default: w_next = WAIT_LOCK;
        endcase
    end

    always_comb begin
        w_stay_run    = (r_state == RUN) && (w_next == RUN);
        w_stay_settle = (r_state == SETTLE) && (w_next == SETTLE);
        w_run_next    = (w_next == RUN);
    end

    // Counter is zero on every SETTLE entry, so a lock glitch restarts the full interval.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (w_stay_settle) begin
            r_cnt <= r_cnt + 1'b1;
        end else begin
            r_cnt <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ready     <= 1'b0;
            r_rst_out_n <= 1'b0;
        end else begin
            r_ready     <= w_run_next;
            r_rst_out_n <= w_run_next;
        end
    end

    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            w_sum[i] = {1'b0, r_acc[i]} + {1'b0, step[i*ACC_W +: ACC_W]};
        end
    end

    // The entry edge into RUN does not accumulate; the first addition is on the next edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ce <= '0;
            for (int i = 0; i < NCH; i++) r_acc[i] <= '0;
        end else if (!w_stay_run) begin
            r_ce <= '0;
            for (int i = 0; i < NCH; i++) r_acc[i] <= '0;
        end else if (phase_load) begin
            r_ce <= '0;
            for (int i = 0; i < NCH; i++) r_acc[i] <= phase[i*ACC_W +: ACC_W];
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (ch_en[i]) begin
                    r_acc[i] <= w_sum[i][ACC_W-1:0];
                    r_ce[i]  <= w_sum[i][ACC_W];
                end else begin
                    r_ce[i]  <= 1'b0;
                end
            end
        end
    end

    assign ce        = r_ce;
    assign ready     = r_ready;
    assign rst_out_n = r_rst_out_n;

endmodule

// File: tb/tb_pll_ce_gen.sv
// Directed bench for pll_ce_gen: lock sequencing, strobe ratios, gating, phase load,
// lock loss and asynchronous reset, with SETTLE_CYCLES = 16.
module tb_pll_ce_gen;

    localparam int NCH   = 4;
    localparam int ACC_W = 16;
    localparam int SC    = 16;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 pll_lock;
    logic [ACC_W-1:0]     s0, s1, s2, s3;
    logic [NCH*ACC_W-1:0] step;
    logic [NCH*ACC_W-1:0] phase;
    logic                 phase_load;
    logic [NCH-1:0]       ch_en;
    logic [NCH-1:0]       ce;
    logic                 ready;
    logic                 rst_out_n;

    assign step = {s3, s2, s1, s0};

    pll_ce_gen #(
        .NCH(NCH), .ACC_W(ACC_W), .SETTLE_CYCLES(SC)
    ) dut (
        .clk(clk), .rst_n(rst_n), .pll_lock(pll_lock), .step(step), .phase(phase),
        .phase_load(phase_load), .ch_en(ch_en), .ce(ce), .ready(ready),
        .rst_out_n(rst_out_n)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [3:0]  en;
        logic [15:0] st0;
        logic        pl;
        logic [3:0]  exp_ce;
    } vec_t;

    vec_t tv [34];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_vecs(input int a, input int b);
        for (int i = a; i <= b; i++) begin
            ch_en      = tv[i].en;
            s0         = tv[i].st0;
            phase_load = tv[i].pl;
            tick();
            phase_load = 1'b0;
            chk($sformatf("vec%0d_ce", i), 32'(ce), 32'(tv[i].exp_ce));
        end
    endtask

    int cnt [4];
    int last2;
    int gap_bad;
    int wid_bad;
    logic prev2;

    initial begin
        // k=1..8 after RUN: steps {FFFF, 0, 4000, 8000}
        tv[0]  = '{4'b1111, 16'h8000, 1'b0, 4'b0000};
        tv[1]  = '{4'b1111, 16'h8000, 1'b0, 4'b1001};
        tv[2]  = '{4'b1111, 16'h8000, 1'b0, 4'b1000};
        tv[3]  = '{4'b1111, 16'h8000, 1'b0, 4'b1011};
        tv[4]  = '{4'b1111, 16'h8000, 1'b0, 4'b1000};
        tv[5]  = '{4'b1111, 16'h8000, 1'b0, 4'b1001};
        tv[6]  = '{4'b1111, 16'h8000, 1'b0, 4'b1000};
        tv[7]  = '{4'b1111, 16'h8000, 1'b0, 4'b1011};
        // channel gate on ch1, step change on ch0, phase load on an overflow edge
        tv[8]  = '{4'b0011, 16'h8000, 1'b0, 4'b0000};
        tv[9]  = '{4'b0011, 16'h8000, 1'b0, 4'b0001};
        tv[10] = '{4'b0001, 16'h8000, 1'b0, 4'b0000};
        tv[11] = '{4'b0001, 16'h8000, 1'b0, 4'b0001};
        tv[12] = '{4'b0001, 16'h8000, 1'b0, 4'b0000};
        tv[13] = '{4'b0001, 16'h8000, 1'b0, 4'b0001};
        tv[14] = '{4'b0001, 16'h8000, 1'b0, 4'b0000};
        tv[15] = '{4'b0011, 16'h8000, 1'b0, 4'b0001};
        tv[16] = '{4'b0011, 16'h8000, 1'b0, 4'b0010};
        tv[17] = '{4'b0011, 16'h4000, 1'b0, 4'b0000};
        tv[18] = '{4'b0011, 16'h4000, 1'b0, 4'b0001};
        tv[19] = '{4'b0011, 16'h4000, 1'b0, 4'b0000};
        tv[20] = '{4'b0011, 16'h4000, 1'b0, 4'b0010};
        tv[21] = '{4'b0011, 16'h4000, 1'b0, 4'b0000};
        tv[22] = '{4'b0011, 16'h4000, 1'b0, 4'b0001};
        tv[23] = '{4'b0011, 16'h4000, 1'b0, 4'b0000};
        tv[24] = '{4'b0011, 16'h4000, 1'b1, 4'b0000};
        tv[25] = '{4'b0011, 16'h4000, 1'b0, 4'b0011};
        tv[26] = '{4'b0011, 16'h4000, 1'b0, 4'b0000};
        tv[27] = '{4'b0011, 16'h4000, 1'b0, 4'b0000};
        tv[28] = '{4'b0011, 16'h4000, 1'b0, 4'b0000};
        tv[29] = '{4'b0011, 16'h4000, 1'b0, 4'b0011};
        // after the lock glitch: a SETTLE-time phase_load must have been ignored
        tv[30] = '{4'b0001, 16'h4000, 1'b0, 4'b0000};
        tv[31] = '{4'b0001, 16'h4000, 1'b0, 4'b0000};
        tv[32] = '{4'b0001, 16'h4000, 1'b0, 4'b0000};
        tv[33] = '{4'b0001, 16'h4000, 1'b0, 4'b0001};

        rst_n      = 1'b0;
        pll_lock   = 1'b1;
        phase_load = 1'b0;
        ch_en      = 4'b1111;
        s0 = 16'h8000; s1 = 16'h4000; s2 = 16'h0000; s3 = 16'hFFFF;
        phase = {4{16'hC000}};

        repeat (2) tick();
        chk("reset_ce", 32'(ce), 32'h0);
        chk("reset_ready", 32'(ready), 32'h0);
        chk("reset_rst_out_n", 32'(rst_out_n), 32'h0);

        rst_n = 1'b1;
        for (int n = 1; n <= 3 + SC; n++) begin
            tick();
            chk($sformatf("startup_ready_e%0d", n), 32'(ready), 32'(n >= 3 + SC));
            chk($sformatf("startup_rstout_e%0d", n), 32'(rst_out_n), 32'(n >= 3 + SC));
            chk($sformatf("startup_ce_e%0d", n), 32'(ce), 32'h0);
        end

        run_vecs(0, 7);

        // ch2 accumulator is still 0 (step was 0), so its count starts clean
        s2 = 16'd2731;
        for (int j = 0; j < 4; j++) cnt[j] = 0;
        last2 = -1; gap_bad = 0; wid_bad = 0; prev2 = 1'b0;
        for (int n = 1; n <= 65536; n++) begin
            tick();
            for (int j = 0; j < 4; j++) cnt[j] += int'(ce[j]);
            if (ce[2]) begin
                if (prev2) wid_bad++;
                if (last2 >= 0 && (n - last2) != 23 && (n - last2) != 24) gap_bad++;
                last2 = n;
            end
            prev2 = ce[2];
        end
        chk("count_ch0_8000", cnt[0], 32768);
        chk("count_ch1_4000", cnt[1], 16384);
        chk("count_ch2_2731", cnt[2], 2731);
        chk("count_ch3_ffff", cnt[3], 65535);
        chk("ch2_gap_23_24", gap_bad, 0);
        chk("ch2_width_1", wid_bad, 0);

        run_vecs(8, 29);

        // lock loss: ch0 would strobe on the third edge, but must be forced low
        pll_lock = 1'b0;
        s0 = 16'hFFFF;
        tick();
        chk("lockloss_e1_ready", 32'(ready), 32'h1);
        chk("lockloss_e1_ce", 32'(ce), 32'h0);
        tick();
        chk("lockloss_e2_ready", 32'(ready), 32'h1);
        chk("lockloss_e2_ce", 32'(ce), 32'h1);
        tick();
        chk("lockloss_e3_ready", 32'(ready), 32'h0);
        chk("lockloss_e3_rstout", 32'(rst_out_n), 32'h0);
        chk("lockloss_e3_ce", 32'(ce), 32'h0);
        tick();
        chk("lockloss_e4_ce", 32'(ce), 32'h0);

        // relock, glitch during SETTLE; phase_load pulsed while not in RUN
        pll_lock = 1'b1;
        s0 = 16'h4000;
        ch_en = 4'b0001;
        for (int n = 1; n <= 8; n++) begin
            if (n == 6) phase_load = 1'b1;
            tick();
            phase_load = 1'b0;
            chk($sformatf("settle_ready_e%0d", n), 32'(ready), 32'h0);
        end
        pll_lock = 1'b0;
        tick();
        pll_lock = 1'b1;
        for (int n = 1; n <= 3 + SC; n++) begin
            tick();
            chk($sformatf("relock_ready_e%0d", n), 32'(ready), 32'(n >= 3 + SC));
            chk($sformatf("relock_rstout_e%0d", n), 32'(rst_out_n), 32'(n >= 3 + SC));
        end

        run_vecs(30, 33);

        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_ce", 32'(ce), 32'h0);
        chk("async_rst_ready", 32'(ready), 32'h0);
        chk("async_rst_rstout", 32'(rst_out_n), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("after_rst_ready", 32'(ready), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pll_ce_gen.md
# pll_ce_gen

Multi-channel clock-enable generator that sits directly behind the system PLL, which produces the 72 MHz master clock from the 27 MHz board oscillator. It waits for PLL lock and a settling interval, then releases a synchronous system reset and produces NCH independent single-cycle enable strobes. Each strobe runs at a programmable fractional rate f_clk·step/2^ACC_W with a loadable phase. It replaces fixed per-rate divider chains, such as the CPU, timer and video enables, with one parametrised block.

## Interface
- NCH, 4: number of enable channels.
- ACC_W, 16: phase-accumulator width per channel.
- SETTLE_CYCLES, 1024: clk cycles to wait after synchronised lock before RUN; must be ≥ 1.
- clk  in  1  master clock, PLL output.
- rst_n  in  1  asynchronous, active-low reset; one clock domain (clk) only.
- pll_lock  in  1  PLL lock, asynchronous to clk; passed through a 2-flop synchroniser inside the block.
- step  in  NCH·ACC_W  per-channel increment; channel i uses bits [i·ACC_W +: ACC_W].
- phase  in  NCH·ACC_W  per-channel accumulator preload value.
- phase_load  in  1  one-cycle pulse; loads `phase` into all accumulators.
- ch_en  in  NCH  per-channel enable; a disabled channel holds its accumulator and emits no strobe.
- ce  out  NCH  registered one-cycle enable strobes.
- ready  out  1  high while state = RUN.
- rst_out_n  out  1  synchronous system reset for downstream logic, active-low.

## Operation
- Lock synchroniser: two flops, both reset to 0; lock_s is the second flop.
- FSM states WAIT_LOCK, SETTLE, RUN. Reset state is WAIT_LOCK.
  - WAIT_LOCK → SETTLE when lock_s = 1. The settle counter is cleared on entry.
  - SETTLE: the counter increments each cycle. SETTLE → RUN on the edge where the counter reaches SETTLE_CYCLES−1. If lock_s = 0 during SETTLE, go to WAIT_LOCK.
  - RUN → WAIT_LOCK when lock_s = 0.
- Accumulators are held at 0 in every state except RUN, and are cleared on every transition out of RUN.
- Per-channel behaviour in RUN with ch_en[i] = 1: {carry, acc_i} <= acc_i + step_i as an (ACC_W+1)-bit sum, and ce[i] <= carry.
- Per-channel behaviour in RUN with ch_en[i] = 0: acc_i holds and ce[i] <= 0.
- phase_load in RUN: acc_i <= phase_i for every channel regardless of ch_en, and ce <= 0 on that edge. The load takes priority over accumulation and over any carry on the same edge.
- phase_load outside RUN is ignored.
- step and ch_en are sampled every edge. A change applies to the very next addition, with no glitch or extra strobe.
- step = 0 gives no strobes. step = 2^ACC_W−1 gives one missing strobe per 2^ACC_W cycles.
- Long-run strobe rate is exactly step/2^ACC_W per cycle; there is no cumulative error.

## Timing
- Reset values: ce = 0, ready = 0, rst_out_n = 0, all accumulators = 0, settle counter = 0, state = WAIT_LOCK.
- pll_lock rising edge to entering SETTLE: 3 edges (2 synchroniser flops + FSM).
- SETTLE lasts exactly SETTLE_CYCLES edges.
- ready and rst_out_n are registered. Both go high on the same edge the FSM enters RUN, and both go low on the same edge it leaves RUN.
- Lock loss to ready = 0: 3 edges after pll_lock falls. ce is forced to 0 on that same edge.
- Strobe timing, with edge 1 being the first RUN edge and acc = 0: ce[i] is high during the cycle after edge k, for each k where floor(k·step/2^ACC_W) increments.
- Strobe width is always exactly one clk cycle.
- A phase_load on edge k means the next possible strobe is after edge k+1.
- rst_n asserted mid-operation clears all outputs immediately and asynchronously. Deassertion restarts from WAIT_LOCK.

## Test plan
- Reset/lock sequencing: rst_n low then high, pll_lock tied 1, SETTLE_CYCLES = 16 → ready and rst_out_n rise exactly 3+16 edges after rst_n deasserts; ce stays 0 until then.
- Basic ratios, ACC_W = 16:
  - step0 = 0x8000 → ce[0] high every 2nd cycle.
  - step1 = 0x4000 → ce[1] high every 4th cycle, first after edge 4.
  - step2 = 0 → no strobes.
  - step3 = 0xFFFF → exactly 65535 strobes in 65536 cycles.
- Fractional rate: step = 2731 (≈3 MHz at 72 MHz), run 72000 cycles → exactly 3000 strobes; each strobe is one cycle wide; gaps are only 23 or 24 cycles.
- Phase load: step = 0x4000, phase = 0xC000 loaded on the same edge an overflow would occur → no ce after that edge, then ce after the next edge, then every 4th cycle.
- Channel gate and step change: drop ch_en[1] for 5 cycles mid-count → strobes resume with the accumulator value preserved. Change step0 from 0x8000 to 0x4000 → the new 4-cycle period starts from the current acc with no extra strobe.
- Lock loss: deassert pll_lock in RUN → ready, rst_out_n and ce go to 0 on the 3rd edge. Glitch pll_lock low for 1 cycle in SETTLE → the counter restarts; the full SETTLE_CYCLES interval is required again.
